// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ / IDX_W : requester count and encoded index width
//   arb_state_e   : two-state arbitration FSM encoding
//   rr_search     : rotating-priority search returning a one-hot winner
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Scan req starting at bit ptr, ascending and wrapping 7 -> 0, skipping
    // any bit set in mask. Returns the first hit as a one-hot, or all-zero.
    function automatic logic [N_REQ-1:0] rr_search(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr,
        input logic [N_REQ-1:0] mask
    );
        logic [N_REQ-1:0] cand;
        logic [N_REQ-1:0] result;
        logic             found;
        logic [IDX_W-1:0] idx;
        cand   = req & ~mask;
        result = {N_REQ{1'b0}};
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // 3-bit addition wraps naturally from 7 back to 0
            idx = ptr + IDX_W'(k);
            if (!found && cand[idx]) begin
                result[idx] = 1'b1;
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter8_onehot_enc8.sv
// 8-bit one-hot to 3-bit index encoder.
//   onehot : one-hot (or all-zero) input
//   idx    : encoded index, 3'd0 for an all-zero input
module onehot_enc8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // OR-reduction encoder: each index bit collects the positions where it is 1
    assign idx[0] = onehot[1] | onehot[3] | onehot[5] | onehot[7];
    assign idx[1] = onehot[2] | onehot[3] | onehot[6] | onehot[7];
    assign idx[2] = onehot[4] | onehot[5] | onehot[6] | onehot[7];

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource slot between 8 requesters.
// A granted requester keeps the grant while it holds its request, up to
// MAX_HOLD consecutive cycles when others are waiting (0 = unlimited).
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request lines, req[i] = requester i wants/holds the slot
//   gnt       : registered one-hot grant or all-zero
//   gnt_idx   : encoded index of gnt (0 when gnt is zero), drives datapath mux
//   gnt_valid : |gnt
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT =
        (MAX_HOLD == 0) ? {HOLD_W{1'b0}} : HOLD_W'(MAX_HOLD - 1);

    arb_state_e       state_r, state_nxt_s;
    logic [N_REQ-1:0] gnt_r, gnt_nxt_s;
    logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
    logic [HOLD_W-1:0] hold_r, hold_nxt_s;

    logic [N_REQ-1:0] search_mask_s;
    logic [N_REQ-1:0] win_s;
    logic             win_valid_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             cur_req_s;
    logic             hold_ok_s;

    // In GRANT the current holder is excluded so release/rotation never re-picks it
    assign search_mask_s = (state_r == ST_GRANT) ? gnt_r : {N_REQ{1'b0}};
    assign win_s         = rr_search(req, ptr_r, search_mask_s);
    assign win_valid_s   = |win_s;
    assign cur_req_s     = |(req & gnt_r);
    assign hold_ok_s     = (MAX_HOLD == 0) || (hold_r < HOLD_LIMIT);

    onehot_enc8 u_win_enc (
        .onehot (win_s),
        .idx    (win_idx_s)
    );

    onehot_enc8 u_gnt_enc (
        .onehot (gnt_r),
        .idx    (gnt_idx)
    );

    assign gnt       = gnt_r;
    assign gnt_valid = |gnt_r;

    // Next-state, next-grant, hold counter and priority pointer decisions
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        hold_nxt_s  = hold_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_nxt_s = ST_GRANT;
                    gnt_nxt_s   = win_s;
                    hold_nxt_s  = {HOLD_W{1'b0}};
                    ptr_nxt_s   = win_idx_s + 3'd1;
                end else begin
                    gnt_nxt_s   = {N_REQ{1'b0}};
                end
            end
            ST_GRANT: begin
                if (!cur_req_s) begin
                    // Release: hand over directly if anyone else is waiting
                    if (win_valid_s) begin
                        gnt_nxt_s  = win_s;
                        hold_nxt_s = {HOLD_W{1'b0}};
                        ptr_nxt_s  = win_idx_s + 3'd1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        gnt_nxt_s   = {N_REQ{1'b0}};
                        hold_nxt_s  = {HOLD_W{1'b0}};
                    end
                end else if (hold_ok_s) begin
                    hold_nxt_s = hold_r + HOLD_W'(1);
                end else if (win_valid_s) begin
                    // Hold budget used up and someone is waiting: force rotation
                    gnt_nxt_s  = win_s;
                    hold_nxt_s = {HOLD_W{1'b0}};
                    ptr_nxt_s  = win_idx_s + 3'd1;
                end else begin
                    // Nobody waiting: keep the grant, counter stays saturated
                    hold_nxt_s = hold_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = {N_REQ{1'b0}};
                hold_nxt_s  = {HOLD_W{1'b0}};
                ptr_nxt_s   = 3'd0;
            end
        endcase
    end

    // Arbitration state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= {N_REQ{1'b0}};
            ptr_r   <= 3'd0;
            hold_r  <= {HOLD_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: a default instance (MAX_HOLD=16) and a
// MAX_HOLD=4 instance for forced rotation. Expected grants are pushed to a
// queue as each request pattern is driven and popped after the clock edge.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [7:0] req4;
    logic [7:0] gnt4;
    logic [2:0] gnt_idx4;
    logic       gnt_valid4;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    rr_arbiter8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(3)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req4),
        .gnt       (gnt4),
        .gnt_idx   (gnt_idx4),
        .gnt_valid (gnt_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_idx(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        req4  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: gnt=%h idx=%0d valid=%b expected gnt=00 idx=0 valid=0",
                     gnt, gnt_idx, gnt_valid);
        end
        rst_n = 1'b1;
        // first grant after reset release goes to bit 0, then release to idle
        for (int i = 0; i < 2; i++) begin
            req = (i == 0) ? 8'hFF : 8'h00;
            exp_q.push_back((i == 0) ? 8'h01 : 8'h00);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid} !== {e, exp_idx(e), |e}) begin
                n_fail++;
                $display("FAIL reset_first step %0d: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                         i, gnt, gnt_idx, gnt_valid, e, exp_idx(e), |e);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req = (i < 5) ? 8'h08 : 8'h00;
            exp_q.push_back((i < 5) ? 8'h08 : 8'h00);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid} !== {e, exp_idx(e), |e}) begin
                n_fail++;
                $display("FAIL single step %0d: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                         i, gnt, gnt_idx, gnt_valid, e, exp_idx(e), |e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] one;
        do_reset();
        one = 8'h01;
        // each new holder drops its bit once granted: 0,1,..,7,0 with no gaps
        for (int i = 0; i < 9; i++) begin
            req = (i == 0) ? 8'hFF : ~(one << (i - 1));
            exp_q.push_back(one << (i % 8));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid} !== {e, exp_idx(e), |e}) begin
                n_fail++;
                $display("FAIL round_robin step %0d: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                         i, gnt, gnt_idx, gnt_valid, e, exp_idx(e), |e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] stim[5];
        logic [7:0] expv[5];
        stim = '{8'h40, 8'h00, 8'h41, 8'h40, 8'h00};
        expv = '{8'h40, 8'h00, 8'h01, 8'h40, 8'h00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid} !== {e, exp_idx(e), |e}) begin
                n_fail++;
                $display("FAIL wrap step %0d: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                         i, gnt, gnt_idx, gnt_valid, e, exp_idx(e), |e);
            end
        end
    endtask

    task automatic test_max_hold();
        do_reset();
        // contention: 4 cycles each, alternating; then sole requester keeps it
        for (int i = 0; i < 26; i++) begin
            req4 = (i < 16) ? 8'h24 : 8'h04;
            if (i < 16) exp_q.push_back((((i / 4) % 2) == 0) ? 8'h04 : 8'h20);
            else        exp_q.push_back(8'h04);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({gnt4, gnt_idx4, gnt_valid4} !== {e, exp_idx(e), |e}) begin
                n_fail++;
                $display("FAIL max_hold step %0d: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                         i, gnt4, gnt_idx4, gnt_valid4, e, exp_idx(e), |e);
            end
        end
        req4 = 8'h00;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            req = (i == 0) ? 8'h20 : 8'hFF;
            exp_q.push_back(8'h20);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid} !== {e, exp_idx(e), |e}) begin
                n_fail++;
                $display("FAIL async_pre step %0d: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                         i, gnt, gnt_idx, gnt_valid, e, exp_idx(e), |e);
            end
        end
        // mid-cycle reset: outputs must clear before the next rising edge
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%h idx=%0d valid=%b expected gnt=00 idx=0 valid=0",
                     gnt, gnt_idx, gnt_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req = 8'hFF;
        exp_q.push_back(8'h01);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {e, exp_idx(e), |e}) begin
            n_fail++;
            $display("FAIL async_restart: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                     gnt, gnt_idx, gnt_valid, e, exp_idx(e), |e);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 8'h00;
        req4    = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_max_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
